red_centroid_tracker: RTL

Downstream consumer of the per-pixel red colour filter. Accumulates the X/Y coordinates of every surviving (non-black) pixel over a frame. At end of frame it snapshots the sums and runs a shared iterative divider to produce the target centroid and pixel count. Sits between the filter output and the control/host interface that steers tracking.

---
 rtl/red_centroid_tracker.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/red_centroid_tracker.sv
// red_centroid_tracker
// Accumulates the coordinates of every non-black pixel in a frame. At frame
// end it snapshots the totals, then a shared restoring divider produces the
// X and Y centroids one quotient bit per cycle. The result is published on a
// single oValid pulse a fixed 57 cycles after the frame-end pixel.
module red_centroid_tracker #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int MIN_PIXELS   = 64,
  parameter int SUM_W        = 28,
  parameter int CNT_W        = 19
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [10:0]      iX_Cont,
  input  logic [10:0]      iY_Cont,
  input  logic [11:0]      iRed,
  input  logic [11:0]      iGreen,
  input  logic [11:0]      iBlue,
  input  logic             iDVAL,
  output logic [10:0]      oCentroid_X,
  output logic [10:0]      oCentroid_Y,
  output logic [CNT_W-1:0] oPixel_Count,
  output logic             oFound,
  output logic             oValid,
  output logic             oOverrun
);

  // Frame geometry and thresholds, sized to the ports they are compared with.
  localparam logic [11:0]      X_LIMIT = 12'(FRAME_WIDTH);
  localparam logic [11:0]      Y_LIMIT = 12'(FRAME_HEIGHT);
  localparam logic [10:0]      X_LAST  = 11'(FRAME_WIDTH - 1);
  localparam logic [10:0]      Y_LAST  = 11'(FRAME_HEIGHT - 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  // One divide pass is SUM_W steps; the step counter runs 0..SUM_W-1.
  localparam int               STEP_W    = $clog2(SUM_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

  // Controller states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DIV_X = 2'd1;
  localparam logic [1:0] ST_DIV_Y = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Running per-frame accumulators.
  logic [SUM_W-1:0] sum_x_q, sum_x_d;
  logic [SUM_W-1:0] sum_y_q, sum_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Frame-end snapshot. The X sum is loaded straight into the divider's
  // dividend register, so only Y and the count need holding copies.
  logic [SUM_W-1:0] snap_sum_y_q, snap_sum_y_d;
  logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;

  // Divider: quo holds the dividend shifting out and the quotient shifting in.
  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [SUM_W-1:0]  quo_q, quo_d;
  logic [CNT_W:0]    rem_q, rem_d;
  logic [10:0]       quot_x_q, quot_x_d;

  // Published results.
  logic [10:0]      cent_x_q, cent_x_d;
  logic [10:0]      cent_y_q, cent_y_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             found_q, found_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  // Pixel qualification and this cycle's folded-in totals.
  logic             accepted;
  logic             hit;
  logic             frame_end;
  logic [SUM_W-1:0] sum_x_tot;
  logic [SUM_W-1:0] sum_y_tot;
  logic [CNT_W-1:0] cnt_tot;

  // Divider single-step datapath.
  logic [CNT_W:0]   divisor_ext;
  logic [CNT_W:0]   rem_shift;
  logic             rem_ge;
  logic [CNT_W:0]   rem_next;
  logic [SUM_W-1:0] quo_next;

  // Result formatting for the DONE cycle.
  logic             snap_found;
  logic             snap_zero;

  // Qualify the incoming pixel and add its contribution to the running totals.
  always_comb begin
    accepted  = iDVAL && ({1'b0, iX_Cont} < X_LIMIT) && ({1'b0, iY_Cont} < Y_LIMIT);
    hit       = accepted && (|{iRed, iGreen, iBlue});
    frame_end = accepted && (iX_Cont == X_LAST) && (iY_Cont == Y_LAST);
    sum_x_tot = sum_x_q + (hit ? {{(SUM_W-11){1'b0}}, iX_Cont} : '0);
    sum_y_tot = sum_y_q + (hit ? {{(SUM_W-11){1'b0}}, iY_Cont} : '0);
    cnt_tot   = cnt_q + {{(CNT_W-1){1'b0}}, hit};
    // The frame-end pixel is folded into the totals above, which are handed
    // to the snapshot; the accumulators then restart from zero.
    sum_x_d   = frame_end ? '0 : sum_x_tot;
    sum_y_d   = frame_end ? '0 : sum_y_tot;
    cnt_d     = frame_end ? '0 : cnt_tot;
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    divisor_ext = {1'b0, snap_cnt_q};
    // The remainder always stays below the divisor, so its top bit is zero
    // before the shift and nothing is lost by shifting the whole register.
    rem_shift   = (rem_q << 1) | {{CNT_W{1'b0}}, quo_q[SUM_W-1]};
    rem_ge      = (rem_shift >= divisor_ext);
    rem_next    = rem_ge ? (rem_shift - divisor_ext) : rem_shift;
    quo_next    = {quo_q[SUM_W-2:0], rem_ge};
  end

  // Controller: snapshot at frame end, two divide passes, then publish.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    step_d       = step_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    quot_x_d     = quot_x_q;
    snap_sum_y_d = snap_sum_y_q;
    snap_cnt_d   = snap_cnt_q;
    cent_x_d     = cent_x_q;
    cent_y_d     = cent_y_q;
    pix_cnt_d    = pix_cnt_q;
    found_d      = found_q;
    valid_d      = 1'b0;
    overrun_d    = 1'b0;
    snap_found   = (snap_cnt_q >= MIN_CNT);
    snap_zero    = (snap_cnt_q == '0);

    // A frame end is only taken when idle; otherwise it is dropped and flagged.
    // Its data is still discarded because the accumulators clear regardless.
    if (frame_end) begin
      if (state_q == ST_IDLE) begin
        snap_sum_y_d = sum_y_tot;
        snap_cnt_d   = cnt_tot;
        quo_d        = sum_x_tot;
        rem_d        = '0;
        step_d       = '0;
        state_d      = ST_DIV_X;
      end else begin
        overrun_d    = 1'b1;
      end
    end

    case (state_q)
      ST_DIV_X: begin
        quo_d  = quo_next;
        rem_d  = rem_next;
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) begin
          // Keep the X quotient, reload the divider with the Y dividend.
          quot_x_d = quo_next[10:0];
          quo_d    = snap_sum_y_q;
          rem_d    = '0;
          step_d   = '0;
          state_d  = ST_DIV_Y;
        end
      end
      ST_DIV_Y: begin
        quo_d  = quo_next;
        rem_d  = rem_next;
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // quo_q now holds the Y quotient. A zero count makes the divider
        // produce all-ones, so both quotients are forced to zero then.
        pix_cnt_d = snap_cnt_q;
        found_d   = snap_found;
        cent_x_d  = (snap_found && !snap_zero) ? quot_x_q : '0;
        cent_y_d  = (snap_found && !snap_zero) ? quo_q[10:0] : '0;
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        // Idle: nothing to do until a frame end arrives.
      end
    endcase
  end

  // State registers; reset clears everything and abandons any division.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (iRST) begin
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      cnt_q        <= '0;
      snap_sum_y_q <= '0;
      snap_cnt_q   <= '0;
      state_q      <= ST_IDLE;
      step_q       <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      quot_x_q     <= '0;
      cent_x_q     <= '0;
      cent_y_q     <= '0;
      pix_cnt_q    <= '0;
      found_q      <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      cnt_q        <= cnt_d;
      snap_sum_y_q <= snap_sum_y_d;
      snap_cnt_q   <= snap_cnt_d;
      state_q      <= state_d;
      step_q       <= step_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      quot_x_q     <= quot_x_d;
      cent_x_q     <= cent_x_d;
      cent_y_q     <= cent_y_d;
      pix_cnt_q    <= pix_cnt_d;
      found_q      <= found_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign oCentroid_X  = cent_x_q;
  assign oCentroid_Y  = cent_y_q;
  assign oPixel_Count = pix_cnt_q;
  assign oFound       = found_q;
  assign oValid       = valid_q;
  assign oOverrun     = overrun_q;

endmodule
